// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the ATtiny20 core.
// Steps IF/ID/EX/MEM/WB, counts MEM cycles (with memory wait-states),
// injects interrupt-entry sequences at instruction boundaries and halts
// permanently when memory stalls for too long.
module control_sequencer #(
    parameter int CNT_WIDTH      = 2,
    parameter int ISR_MEM_CYCLES = 2,
    parameter int MEM_TIMEOUT    = 15,
    parameter int TO_WIDTH       = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 instr_valid_i,
    input  logic                 stall_req_i,
    input  logic [CNT_WIDTH-1:0] op_mem_cycles_i,
    input  logic                 op_has_wb_i,
    input  logic                 mem_ready_i,
    input  logic                 irq_pending_i,
    output logic [2:0]           state_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o,
    output logic                 mem_req_o,
    output logic                 in_isr_o,
    output logic                 irq_ack_o,
    output logic                 instr_retired_o,
    output logic                 halted_o
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ISR_CNT  = CNT_WIDTH'(ISR_MEM_CYCLES);
    localparam logic [TO_WIDTH-1:0]  WAIT_MAX = TO_WIDTH'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [TO_WIDTH-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0]   mem_cycles_q, mem_cycles_d;
    logic                   has_wb_q, has_wb_d;
    logic                   in_isr_q, in_isr_d;
    logic                   halted_q, halted_d;
    logic                   eoi;
    logic                   retire;
    logic                   ack;

    // Next-state logic: phase sequencing, MEM cycle counting and ISR injection.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        mem_cycles_d = mem_cycles_q;
        has_wb_d     = has_wb_q;
        in_isr_d     = in_isr_q;
        halted_d     = halted_q;
        eoi          = 1'b0;
        retire       = 1'b0;
        ack          = 1'b0;

        case (state_q)
            S_IF: if (instr_valid_i) state_d = S_ID;
            S_ID: begin
                if (!stall_req_i) begin
                    mem_cycles_d = op_mem_cycles_i;
                    has_wb_d     = op_has_wb_i;
                    state_d      = S_EX;
                end
            end
            S_EX: begin
                if (mem_cycles_q != '0) state_d = S_MEM;
                else if (has_wb_q)      state_d = S_WB;
                else                    eoi     = 1'b1;
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    wait_d = '0;
                    if (cnt_q == mem_cycles_q - CNT_WIDTH'(1)) begin
                        cnt_d = '0;
                        if (has_wb_q) state_d = S_WB;
                        else          eoi     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    wait_d = wait_q + TO_WIDTH'(1);
                    if (wait_q == WAIT_MAX) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
            S_WB:   eoi = 1'b1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase

        // Instruction boundary: finish an ISR call, or retire and maybe inject one.
        if (eoi) begin
            if (in_isr_q) begin
                in_isr_d = 1'b0;
                state_d  = S_IF;
            end else begin
                retire = 1'b1;
                if (irq_pending_i) begin
                    ack          = 1'b1;
                    in_isr_d     = 1'b1;
                    mem_cycles_d = ISR_CNT;
                    has_wb_d     = 1'b0;
                    state_d      = S_EX;
                end else begin
                    state_d = S_IF;
                end
            end
        end
    end

    // State register with synchronous reset that overrides every event, HALT included.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_i) begin
            state_q      <= S_IF;
            cnt_q        <= '0;
            wait_q       <= '0;
            mem_cycles_q <= '0;
            has_wb_q     <= 1'b0;
            in_isr_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            mem_cycles_q <= mem_cycles_d;
            has_wb_q     <= has_wb_d;
            in_isr_q     <= in_isr_d;
            halted_q     <= halted_d;
        end
    end

    assign state_o         = state_q;
    assign cycle_count_o   = cnt_q;
    assign mem_req_o       = (state_q == S_MEM);
    assign in_isr_o        = in_isr_q;
    assign halted_o        = halted_q;
    // Boundary pulses are suppressed while reset is applied.
    assign instr_retired_o = retire & ~reset_i;
    assign irq_ack_o       = ack & ~reset_i;

endmodule
